lpm_mem_delay: RTL
==================

Name: lpm_mem_delay

Overview:
- Memory-latency model that sits directly downstream of the Lpm pipeline controller.
- Accepts lookup requests from the enter/recirc rules and holds each one for a programmable number of memdelay rule firings.
- Presents the oldest completed entry as a response, which the exit/recirc rules consume.
- Buffers up to DEPTH requests in order and increments a hop counter in each response so recirculation can be tracked.

Parameters:
- DATA_W, 704, width of request/response token
- DEPTH, 4, maximum outstanding requests (power of two, 2..16)
- DELAY, 3, memdelay firings required before an entry completes (1..15)
- HOP_LSB, 32, LSB of the 32-bit hop field inside the token

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req__ENA  in  1  request enqueue strobe
- req_v  in  DATA_W  request token
- req__RDY  out  1  buffer can accept a request
- resAccept__ENA  in  1  consume head response
- resAccept__RDY  out  1  head response is complete
- resValue  out  DATA_W  head response token
- resValue__RDY  out  1  resValue is valid (equals resAccept__RDY)
- rule_enable  in  1  scheduler enable for internal memdelay rule (bit 0)
- rule_ready  out  1  memdelay__RDY (bit 0)

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries. Each entry holds a token plus a 4-bit countdown.
  - rd_ptr and wr_ptr are log2(DEPTH) bits wide, with a (log2(DEPTH)+1)-bit count.
- Reset (async, nRST low):
  - rd_ptr=wr_ptr=count=0 and all countdowns=0.
  - Outputs: req__RDY=1, resAccept__RDY=0, resValue__RDY=0, rule_ready=0, resValue=0.
  - Buffered tokens are discarded.
  - Reset asserted mid-operation drops all in-flight entries immediately. No response is produced after reset is released.
- Enqueue:
  - req__RDY = (count < DEPTH).
  - A request fires when req__ENA && req__RDY. The entry at wr_ptr is loaded with req_v and countdown=DELAY, and wr_ptr wraps modulo DEPTH.
  - req__ENA while not ready is ignored. The bench flags it as a protocol error.
- memdelay rule:
  - memdelay__RDY = (some valid entry has countdown != 0).
  - It fires when rule_enable[0] && memdelay__RDY. Every valid entry with a nonzero countdown decrements by 1 in that cycle.
  - Countdowns freeze while the rule does not fire.
  - A newly enqueued entry does not decrement in its enqueue cycle.
- Completion/response:
  - Head = rd_ptr. resAccept__RDY = resValue__RDY = (count != 0) && (head countdown == 0).
  - resValue = head token with bits [HOP_LSB+31:HOP_LSB] replaced by (hop + 1) mod 2^32. This path is combinational from registered state, with no extra latency.
  - resValue is 0 when not valid.
  - Responses leave strictly in request order. A younger completed entry waits behind an incomplete head.
- Dequeue:
  - resAccept__ENA && resAccept__RDY advances rd_ptr (with wrap).
- Simultaneous events:
  - Enqueue and dequeue in the same cycle (recirc) are legal. count is unchanged.
  - req__RDY is computed from pre-cycle count, with no full-bypass: at count==DEPTH a same-cycle dequeue does not enable an enqueue.
  - An enqueue into the slot freed by the same cycle's dequeue is impossible by construction.
- Minimum latency:
  - Enqueue at cycle t with memdelay firing every cycle gives resAccept__RDY at cycle t+DELAY.
- Hop wrap: hop 0xFFFFFFFF is returned as 0x00000000.
- Countdown and data registers have no reset requirement beyond the valid/count state, except that countdowns reset to 0.

Decomposition:
- Shared package holds:
  - LPM token width (704) and hop-field offset/width.
  - lpm_mem_delay_RULE_COUNT = 1, for the parent's rule_enable slicing.
- A natural sub-module is lpm_delay_slot: one entry's token register, countdown, and a decrement/load/zero flag. It is instantiated DEPTH times.
- Pointer/count logic stays in the top.

Test Plan:
- Single request, DELAY=3, rule_enable=1 continuously:
  - Stimulus: enqueue at cycle 10 with hop=5.
  - Response: resAccept__RDY rises at cycle 13 with hop field 6; resAccept at 13 returns count to 0.
- Stalled rule:
  - Stimulus: enqueue, then hold rule_enable=0 for 20 cycles.
  - Response: resAccept__RDY stays 0 and rule_ready stays 1; it completes exactly 3 enabled firings after re-enable.
- Fill to DEPTH=4:
  - Stimulus: four back-to-back enqueues, then a fifth attempt.
  - Response: req__RDY=0 after the fourth; responses appear in order with tokens 1,2,3,4 and hops incremented; req__RDY returns 1 the cycle after the first dequeue.
- Recirc:
  - Stimulus: simultaneous resAccept and req of the returned token, repeated 3 times, starting from hop=0.
  - Response: count stays constant; final response hop=3, after 9 enabled memdelay firings.
- Wrap and hop overflow:
  - Stimulus: 10 enqueue/dequeue pairs (pointer wraps twice) with hop=0xFFFFFFFF.
  - Response: each response hop=0, order is preserved, and there is no spurious resValue__RDY.
- Async reset mid-flight:
  - Stimulus: 3 entries pending; pulse nRST low between clock edges.
  - Response: all outputs reach reset values immediately (req__RDY=1, resAccept__RDY=0); no response is produced after release.

Source files
------------

// File: rtl/lpm_mem_delay_pkg.sv
// Shared constants for the Lpm memory-latency model: token geometry,
// hop-field location, countdown width and rule count for the parent scheduler.
// No logic; latency and backpressure are defined by the modules importing it.
package lpm_mem_delay_pkg;

    // Lpm request/response token width.
    localparam int LPM_DATA_W = 704;

    // Hop counter field inside the token.
    localparam int LPM_HOP_LSB = 32;
    localparam int LPM_HOP_W   = 32;

    // Per-entry countdown width; DELAY is limited to 1..15.
    localparam int LPM_CD_W = 4;

    // Number of internal rules exposed on rule_enable/rule_ready (memdelay only).
    localparam int lpm_mem_delay_RULE_COUNT = 1;

    typedef logic [LPM_CD_W-1:0] cdown_t;

endpackage

// File: rtl/lpm_delay_slot.sv
// One buffer entry: token register plus a countdown with load/decrement and a zero flag.
// Latency: load/decrement take effect at the next CLK edge; cnt_zero/dat are direct register outputs.
// Backpressure: none here; the parent decides when to load or decrement.
// Ports: load/load_dat/load_cnt write the entry, dec steps the countdown, dat/cnt_zero report state.
module lpm_delay_slot
    import lpm_mem_delay_pkg::*;
#(
    parameter int DATA_W = LPM_DATA_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic [DATA_W-1:0] load_dat,
    input  cdown_t            load_cnt,
    input  logic              dec,
    output logic [DATA_W-1:0] dat,
    output logic              cnt_zero
);

    cdown_t cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_cnt;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Token storage needs no reset: the parent masks the output while the entry is not valid.
    always_ff @(posedge CLK) begin
        if (load) begin
            dat <= load_dat;
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/lpm_mem_delay.sv
// Lpm memory-latency model: in-order buffer that releases each request after DELAY memdelay firings, hop field +1.
// Latency: enqueue at edge t, memdelay firing each cycle -> resAccept__RDY after edge t+DELAY; response path combinational.
// Backpressure: req__RDY drops at DEPTH entries (no same-cycle full bypass); an incomplete head blocks younger entries.
// Ports: req__ENA/req_v/req__RDY enqueue, resAccept__ENA/resAccept__RDY/resValue/resValue__RDY dequeue,
//        rule_enable[0]/rule_ready scheduler handshake for the memdelay rule.
module lpm_mem_delay
    import lpm_mem_delay_pkg::*;
#(
    parameter int DATA_W  = LPM_DATA_W,
    parameter int DEPTH   = 4,
    parameter int DELAY   = 3,
    parameter int HOP_LSB = LPM_HOP_LSB
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic                                req__ENA,
    input  logic [DATA_W-1:0]                   req_v,
    output logic                                req__RDY,
    input  logic                                resAccept__ENA,
    output logic                                resAccept__RDY,
    output logic [DATA_W-1:0]                   resValue,
    output logic                                resValue__RDY,
    input  logic [lpm_mem_delay_RULE_COUNT-1:0] rule_enable,
    output logic                                rule_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [DEPTH-1:0]  slot_vld;
    logic [DEPTH-1:0]  slot_zero;
    logic [DEPTH-1:0]  slot_load;
    logic [DEPTH-1:0]  slot_dec;
    logic [DATA_W-1:0] slot_dat [DEPTH];

    logic [PTR_W-1:0]     age;
    logic                 enq;
    logic                 deq;
    logic                 md_rdy;
    logic                 md_fire;
    logic                 head_done;
    logic [DATA_W-1:0]    head_dat;
    logic [LPM_HOP_W-1:0] head_hop;

    // An entry is valid when its distance from the head is below the occupancy.
    always_comb begin
        slot_vld = '0;
        age      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age         = PTR_W'(i) - rd_ptr;
            slot_vld[i] = ({1'b0, age} < count);
        end
    end

    assign req__RDY  = (count < CNT_W'(DEPTH));
    assign enq       = req__ENA && req__RDY;

    assign md_rdy    = |(slot_vld & ~slot_zero);
    assign md_fire   = rule_enable[0] && md_rdy;
    assign rule_ready = md_rdy;

    // The slot being loaded is never valid beforehand, so a new entry is not decremented in its enqueue cycle.
    assign slot_dec  = slot_vld & ~slot_zero & {DEPTH{md_fire}};
    assign slot_load = enq ? (DEPTH'(1) << wr_ptr) : '0;

    assign head_dat  = slot_dat[rd_ptr];
    assign head_done = (count != '0) && slot_zero[rd_ptr];
    assign head_hop  = head_dat[HOP_LSB +: LPM_HOP_W] + LPM_HOP_W'(1);

    assign resAccept__RDY = head_done;
    assign resValue__RDY  = head_done;
    assign deq            = resAccept__ENA && head_done;

    always_comb begin
        resValue = '0;
        if (head_done) begin
            resValue                         = head_dat;
            resValue[HOP_LSB +: LPM_HOP_W]   = head_hop;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        lpm_delay_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .CLK      (CLK),
            .nRST     (nRST),
            .load     (slot_load[g]),
            .load_dat (req_v),
            .load_cnt (LPM_CD_W'(DELAY)),
            .dec      (slot_dec[g]),
            .dat      (slot_dat[g]),
            .cnt_zero (slot_zero[g])
        );
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
